sar: RTL and testbench



---
 rtl/sar.sv | 72 +++++++
 tb/tb_sar.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sar.sv
// sar: control FSM for a 10-bit successive-approximation ADC.
// The one-hot strobe register doubles as the BIT10..BIT1 state index.
module sar (
  input  logic CLKS,
  input  logic rstn,
  input  logic D_GND,
  input  logic valid,
  input  logic outn,
  output logic CLK10,
  output logic CLK9,
  output logic CLK8,
  output logic CLK7,
  output logic CLK6,
  output logic CLK5,
  output logic CLK4,
  output logic CLK3,
  output logic CLK2,
  output logic CLK1,
  output logic CLKC,
  output logic D9,
  output logic D8,
  output logic D7,
  output logic D6,
  output logic D5,
  output logic D4,
  output logic D3,
  output logic D2,
  output logic D1,
  output logic D0
);
  typedef enum logic [1:0] {IDLE, SAMPLE, BITS, DONE} state_t;
  state_t state_q;
  logic [9:0] strb_q, work_q, work_d, d_q;
  logic clkc_q;
  // The active strobe selects which working bit takes this edge's decision.
  assign work_d = work_q | (strb_q & {10{~outn}});
  always_ff @(posedge CLKS or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      strb_q  <= '0;
      work_q  <= '0;
      d_q     <= '0;
      clkc_q  <= 1'b0;
    end else if (!D_GND) begin
      state_q <= IDLE;
      strb_q  <= '0;
      clkc_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:   state_q <= SAMPLE;
        SAMPLE: begin
          state_q <= BITS;
          work_q  <= '0;
          strb_q  <= 10'h200;
          clkc_q  <= 1'b1;
        end
        BITS: if (valid) begin
          work_q <= work_d;
          strb_q <= strb_q >> 1;
          if (strb_q[0]) begin
            state_q <= DONE;
            d_q     <= work_d;
            clkc_q  <= 1'b0;
          end
        end
        DONE:   state_q <= SAMPLE;
      endcase
    end
  assign {CLK10, CLK9, CLK8, CLK7, CLK6, CLK5, CLK4, CLK3, CLK2, CLK1} = strb_q;
  assign {D9, D8, D7, D6, D5, D4, D3, D2, D1, D0} = d_q;
  assign CLKC = clkc_q;
endmodule

// File: tb/tb_sar.sv
// tb_sar: random and directed stimulus for sar, checked by a phase-level
// reference model and a scoreboard of expected conversion codes.
module tb_sar;
  logic CLKS = 1'b0, rstn = 1'b0, D_GND = 1'b0, valid = 1'b0, outn = 1'b1;
  logic CLK10, CLK9, CLK8, CLK7, CLK6, CLK5, CLK4, CLK3, CLK2, CLK1, CLKC;
  logic D9, D8, D7, D6, D5, D4, D3, D2, D1, D0;
  logic [9:0] strb, dout;
  assign strb = {CLK10, CLK9, CLK8, CLK7, CLK6, CLK5, CLK4, CLK3, CLK2, CLK1};
  assign dout = {D9, D8, D7, D6, D5, D4, D3, D2, D1, D0};

  sar dut (
    .CLKS(CLKS), .rstn(rstn), .D_GND(D_GND), .valid(valid), .outn(outn),
    .CLK10(CLK10), .CLK9(CLK9), .CLK8(CLK8), .CLK7(CLK7), .CLK6(CLK6),
    .CLK5(CLK5), .CLK4(CLK4), .CLK3(CLK3), .CLK2(CLK2), .CLK1(CLK1),
    .CLKC(CLKC),
    .D9(D9), .D8(D8), .D7(D7), .D6(D6), .D5(D5),
    .D4(D4), .D3(D3), .D2(D2), .D1(D1), .D0(D0)
  );

  always #5 CLKS = ~CLKS;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ph 0 idle, 1 sample, 2..11 bit phases (BIT10..BIT1), 12 done.
  int ph = 0, n_done = 0;
  logic [9:0] acc = '0, exp_d = '0;
  logic [9:0] exp_q[$];
  always @(posedge CLKS or negedge rstn) begin
    if (!rstn) begin
      ph = 0; acc = '0; exp_d = '0; exp_q.delete();
    end else if (!D_GND) ph = 0;
    else if (ph == 0) ph = 1;
    else if (ph == 1) begin acc = '0; ph = 2; end
    else if (ph == 12) ph = 1;
    else if (valid) begin
      acc[11-ph] = ~outn;
      if (ph == 11) begin
        exp_d = acc; exp_q.push_back(acc); n_done++; ph = 12;
      end else ph++;
    end
  end

  // Driver: pattern-driven or random comparator responses, changed away from edges.
  logic rnd = 1'b0;
  logic [9:0] pat = '0;
  int stall_k = 0, stall_left = 0;
  always @(negedge CLKS) begin
    if (rnd) begin
      valid = ($urandom_range(0, 9) < 7);
      outn = 1'($urandom_range(0, 1));
    end else if (ph >= 2 && ph <= 11) begin
      if (12 - ph == stall_k && stall_left > 0) begin valid = 1'b0; stall_left--; end
      else valid = 1'b1;
      outn = ~pat[11-ph];
    end else begin
      valid = 1'b1;
      outn = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: per-cycle strobe/invariant checks, scoreboard pop on each completion.
  int run = 0, last_run = 0, c7 = 0;
  always @(negedge CLKS) begin
    logic [9:0] es, e;
    es = (ph >= 2 && ph <= 11) ? 10'(10'b1 << (11 - ph)) : 10'b0;
    chk("strobes", 32'(strb), 32'(es));
    chk("clkc", 32'(CLKC), 32'(es != 0));
    chk("onehot", 32'($countones(strb) <= 1), 32'(1));
    chk("clkc_or", 32'(CLKC), 32'(|strb));
    chk("d_hold", 32'(dout), 32'(exp_d));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scoreboard", 32'(dout), 32'(e));
    end
    if (CLKC) run++;
    else if (run > 0) begin last_run = run; run = 0; end
    if (CLK10) c7 = 0;
    else if (CLK7) c7++;
  end

  task automatic wait_done();
    int start = n_done;
    int i;
    for (i = 0; i < 60 && n_done == start; i++) @(negedge CLKS);
    if (n_done == start) chk("done_timeout", 32'(n_done), 32'(start + 1));
    @(negedge CLKS);
  endtask

  task automatic wait_ph(input int p);
    int i;
    for (i = 0; i < 60 && ph != p; i++) @(negedge CLKS);
    if (ph != p) chk("phase_timeout", 32'(ph), 32'(p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLKS);
    chk("reset_strb", 32'(strb), 0);
    chk("reset_d", 32'(dout), 0);
    rstn = 1'b1;
    pat = 10'h3FF;
    D_GND = 1'b1;
    wait_done();
    chk("ones_d", 32'(dout), 32'h3FF);
    chk("ones_clkc_run", 32'(last_run), 10);
    pat = 10'h2AA;
    wait_done();
    chk("alt_d", 32'(dout), 32'h2AA);
    chk("alt_clkc_run", 32'(last_run), 10);
    pat = 10'h000;
    wait_done();
    chk("zero_d", 32'(dout), 32'h000);
    pat = 10'h2AA; stall_k = 7; stall_left = 3;
    wait_done();
    chk("stall_d", 32'(dout), 32'h2AA);
    chk("stall_clkc_run", 32'(last_run), 13);
    chk("stall_clk7", 32'(c7), 4);
    wait_ph(8);
    D_GND = 1'b0;
    @(negedge CLKS);
    chk("abort_strb", 32'(strb), 0);
    chk("abort_clkc", 32'(CLKC), 0);
    chk("abort_d", 32'(dout), 32'h2AA);
    D_GND = 1'b1; pat = 10'h155;
    wait_done();
    chk("resume_d", 32'(dout), 32'h155);
    wait_ph(6);
    #2 rstn = 1'b0;
    #1;
    chk("async_strb", 32'(strb), 0);
    chk("async_clkc", 32'(CLKC), 0);
    chk("async_d", 32'(dout), 0);
    @(negedge CLKS);
    rstn = 1'b1;
    @(negedge CLKS);
    chk("rel_sample", 32'(CLK10), 0);
    @(negedge CLKS);
    chk("rel_clk10", 32'(CLK10), 1);
    rnd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge CLKS);
      D_GND = ($urandom_range(0, 59) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
